// File: rtl/i2c_apb_pkg.sv
// Shared types and constants for the APB initiator that programs the I2C
// controller's register file: bridge FSM states and register-region codes
// carried on PADDR[7:5].
package i2c_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } apb_state_e;

  // Register regions decoded from address bits [7:5]
  localparam logic [2:0] REGION_PRESCALE = 3'b001;
  localparam logic [2:0] REGION_SLV_ADDR = 3'b010;
  localparam logic [2:0] REGION_STATUS   = 3'b011;
  localparam logic [2:0] REGION_TX       = 3'b100;
  localparam logic [2:0] REGION_RX       = 3'b101;
  localparam logic [2:0] REGION_CMD      = 3'b110;

  // Extract the register region from an 8-bit APB address
  function automatic logic [2:0] addr_region(input logic [7:0] addr);
    return addr[7:5];
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator. A local req/rsp valid-ready handshake is
// turned into one APB SETUP/ACCESS transfer at a time; read data is captured
// RDATA_DLY cycles after completion because the slave registers PRDATA.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYC cycles with PREADY low (response then carries rsp_err=1).
module apb_master_bridge
  import i2c_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RDATA_DLY   = 1,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  // Capture counter: counts CAPTURE cycles, PRDATA taken on the last one
  localparam int unsigned     CAP_W    = (RDATA_DLY > 1) ? $clog2(RDATA_DLY) : 1;
  localparam logic [CAP_W-1:0] CAP_LAST = (RDATA_DLY > 1) ? CAP_W'(RDATA_DLY - 1) : {CAP_W{1'b0}};
  localparam logic [CAP_W-1:0] CAP_ONE  = CAP_W'(1);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CAP_W-1:0]  cap_cnt_q, cap_cnt_d;

`ifdef APB_MASTER_TIMEOUT_EN
  // Timeout counter holds the number of stalled ACCESS cycles seen so far
  localparam int unsigned     TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 1) ? TO_W'(TIMEOUT_CYC - 1) : {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  // Next-state and next-output logic for the transfer FSM
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    cap_cnt_d   = cap_cnt_q;
`ifdef APB_MASTER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Request fields are captured only here; later req_* changes are ignored
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write;
          paddr_d   = req_addr;
          if (req_write) begin
            pwdata_d = req_wdata;
          end else begin
            pwdata_d = pwdata_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        to_cnt_d  = {TO_W{1'b0}};
`endif
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // Completion wins over a timeout reached on the same edge
          psel_d    = 1'b0;
          penable_d = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
          if (pwrite_q) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
          end else if (RDATA_DLY == 0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = PRDATA;
          end else begin
            state_d   = ST_CAPTURE;
            cap_cnt_d = {CAP_W{1'b0}};
          end
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          if (to_cnt_q == TO_LAST) begin
            state_d     = ST_RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ST_ACCESS;
            to_cnt_d = to_cnt_q + TO_ONE;
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end

      ST_CAPTURE: begin
        if (cap_cnt_q == CAP_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = PRDATA;
        end else begin
          state_d   = ST_CAPTURE;
          cap_cnt_d = cap_cnt_q + CAP_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      cap_cnt_q   <= {CAP_W{1'b0}};
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt_q    <= {TO_W{1'b0}};
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cap_cnt_q   <= cap_cnt_d;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
